// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and types for the pipelined ripple adder
//
// Purpose: default geometry of the pipelined ripple adder and the operation
//          encoding carried on its sub input.
// Contents:
//   ADDER_WIDTH   default operand/result width
//   ADDER_STAGES  default number of carry slices (pipeline depth)
//   op_e          OP_ADD (0) / OP_SUB (1), the meaning of the sub input
package adder_pkg;

  localparam int ADDER_WIDTH  = 32;
  localparam int ADDER_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational W-bit ripple-carry slice
//
// Purpose: one carry-chain segment of the pipelined adder. Purely
//          combinational; the caller registers its outputs.
// Optional feature: ADDER_OVF_EN adds the c_msb output.
// Ports:
//   a, b   in  [W-1:0]  operand chunks (b already inverted for subtract)
//   ci     in  1        carry into bit 0 of the slice
//   s      out [W-1:0]  sum chunk
//   co     out 1        carry out of bit W-1
//   c_msb  out 1        carry into bit W-1 (ADDER_OVF_EN only)
module adder_slice
  import adder_pkg::*;
#(
  parameter int W = ADDER_WIDTH / ADDER_STAGES
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
`ifdef ADDER_OVF_EN
  ,
  output logic         c_msb
`endif
);

  // c[i] is the carry into bit i; c[W] leaves the slice.
  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[W];

`ifdef ADDER_OVF_EN
  assign c_msb = c[W-1];
`endif

endmodule

// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - skewed pipelined ripple-carry add/subtract
//
// Purpose: WIDTH-bit a+b+cin or a-b split into STAGES ripple slices of
//          CHUNK = WIDTH/STAGES bits, one register boundary per slice, with a
//          valid/ready handshake on both sides and one operation per cycle.
// Optional feature: ADDER_OVF_EN adds the registered signed-overflow output ovf.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand beat present
//   in_ready   out  1      beat accepted this cycle when in_valid is high
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in for add (ignored for subtract)
//   sub        in   1      0: a+b+cin, 1: a-b
//   out_valid  out  1      result present
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of the top bit (subtract: 1 = no borrow)
//   ovf        out  1      signed overflow (ADDER_OVF_EN only)
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH,
  parameter int STAGES = ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "pipelined_ripple_adder: STAGES must be at least 1");
  end

  if (WIDTH % STAGES != 0) begin : g_bad_width
    $fatal(1, "pipelined_ripple_adder: WIDTH must be a multiple of STAGES");
  end

  localparam int CHUNK = WIDTH / STAGES;

  // ---------------------------------------------------------------------
  // Operand conditioning and global advance
  // ---------------------------------------------------------------------
  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             en;

  assign op    = op_e'(sub);
  assign b_eff = (op == OP_SUB) ? ~b : b;
  // Subtract is a + ~b + 1, so the +1 rides in on the stage-0 carry.
  assign c0    = (op == OP_SUB) ? 1'b1 : cin;

  // The whole pipe moves as one; only a held result can stop it, so bubbles
  // inside the pipe are kept rather than squeezed out during a stall.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------------
  // Skewed stages
  //
  // Stage k finishes sum bits [k*CHUNK +: CHUNK]. Its register holds:
  //   s_r      all sum bits finished so far, (k+1)*CHUNK wide
  //   g_fwd.*  the operand bits not yet summed, shrinking by CHUNK per stage
  //   c_r      carry out of the slice, feeding stage k+1
  //   v_r      valid bit of the beat occupying the stage
  // Narrowing the registers this way gives both skews at once: high operand
  // chunks wait k stages, finished low sum chunks ride along to the end.
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int OPW = WIDTH - k * CHUNK;
    localparam int SW  = (k + 1) * CHUNK;

    logic [OPW-1:0]   op_a;
    logic [OPW-1:0]   op_b;
    logic             carry_in;
    logic             valid_in;
    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
    logic [SW-1:0]    s_next;

    logic [SW-1:0]    s_r;
    logic             c_r;
    logic             v_r;

    if (k == 0) begin : g_head
      assign op_a     = a;
      assign op_b     = b_eff;
      assign carry_in = c0;
      assign valid_in = in_valid;
      assign s_next   = slice_s;
    end else begin : g_body
      assign op_a     = g_stage[k-1].g_fwd.a_r;
      assign op_b     = g_stage[k-1].g_fwd.b_r;
      assign carry_in = g_stage[k-1].c_r;
      assign valid_in = g_stage[k-1].v_r;
      assign s_next   = {slice_s, g_stage[k-1].s_r};
    end

`ifdef ADDER_OVF_EN
    logic slice_cmsb;
`endif

    adder_slice #(
      .W (CHUNK)
    ) u_slice (
      .a     (op_a[CHUNK-1:0]),
      .b     (op_b[CHUNK-1:0]),
      .ci    (carry_in),
      .s     (slice_s),
      .co    (slice_co)
`ifdef ADDER_OVF_EN
      ,
      .c_msb (slice_cmsb)
`endif
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (en) begin
        v_r <= valid_in;
        c_r <= slice_co;
        s_r <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [OPW-CHUNK-1:0] a_r;
      logic [OPW-CHUNK-1:0] b_r;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (en) begin
          a_r <= op_a[OPW-1:CHUNK];
          b_r <= op_b[OPW-1:CHUNK];
        end
      end
    end

`ifdef ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_r;

      // Signed overflow: carry into the sign bit differs from carry out of it.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (en) begin
          ovf_r <= slice_cmsb ^ slice_co;
        end
      end
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Outputs straight from the final stage register
  // ---------------------------------------------------------------------
  assign out_valid = g_stage[STAGES-1].v_r;
  assign sum       = g_stage[STAGES-1].s_r;
  assign cout      = g_stage[STAGES-1].c_r;

`ifdef ADDER_OVF_EN
  assign ovf = g_stage[STAGES-1].g_ovf.ovf_r;
`endif

endmodule
